// File: rtl/custom_logic_pkg.sv
// Shared source encoding for the two-requester arbiter.
package custom_logic_pkg;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

  function automatic src_e other_src(input src_e s);
    return (s == SRC_A) ? SRC_B : SRC_A;
  endfunction

endpackage

// File: rtl/custom_logic_arbiter_if.sv
// Bundle of the two requester streams, the shared output stream and grant counters.
interface custom_logic_arbiter_if #(
  parameter int unsigned D_WIDTH   = 6,
  parameter int unsigned CNT_WIDTH = 8
);
  logic [D_WIDTH-1:0]   up_data_a;
  logic                 up_valid_a;
  logic                 up_ready_a;
  logic [D_WIDTH-1:0]   up_data_b;
  logic                 up_valid_b;
  logic                 up_ready_b;
  logic [D_WIDTH-1:0]   down_data;
  logic                 down_valid;
  logic                 down_ready;
  logic                 down_src;
  logic [CNT_WIDTH-1:0] grant_cnt_a;
  logic [CNT_WIDTH-1:0] grant_cnt_b;

  modport slave (
    input  up_data_a, up_valid_a, up_data_b, up_valid_b, down_ready,
    output up_ready_a, up_ready_b, down_data, down_valid, down_src,
           grant_cnt_a, grant_cnt_b
  );

  modport master (
    output up_data_a, up_valid_a, up_data_b, up_valid_b, down_ready,
    input  up_ready_a, up_ready_b, down_data, down_valid, down_src,
           grant_cnt_a, grant_cnt_b
  );
endinterface

// File: rtl/custom_logic_reg_slice.sv
// Single-entry registered output slot; can pop and reload in the same cycle.
module custom_logic_reg_slice #(
  parameter int unsigned P_WIDTH = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [P_WIDTH-1:0] in_payload,
  output logic               load_en_c,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [P_WIDTH-1:0] out_payload
);

  logic               valid_q, valid_d;
  logic [P_WIDTH-1:0] payload_q, payload_d;

  // in_valid is the accepted handshake, only meaningful while load_en_c is high
  always_comb begin
    load_en_c = !valid_q || out_ready;
    valid_d   = valid_q;
    payload_d = payload_q;
    if (load_en_c) begin
      valid_d = in_valid;
      if (in_valid) payload_d = in_payload;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_payload = payload_q;

endmodule

// File: rtl/custom_logic_arbiter.sv
// Two-input round-robin arbiter feeding one registered output slot, with per-source grant counters.
module custom_logic_arbiter
  import custom_logic_pkg::*;
#(
  parameter int unsigned D_WIDTH   = 6,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  custom_logic_arbiter_if.slave  bus
);

  localparam int unsigned P_WIDTH = D_WIDTH + 1;

  src_e                 prio_last_q, prio_last_d;
  src_e                 grant_src_c;
  logic [CNT_WIDTH-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic                 load_en_c;
  logic                 ready_a_c, ready_b_c;
  logic                 accept_a_c, accept_b_c;
  logic [P_WIDTH-1:0]   in_payload_c;
  logic [P_WIDTH-1:0]   out_payload;
  logic                 out_valid;

  // With no contention the sole requester wins; otherwise (and when idle) the other source is offered
  always_comb begin
    grant_src_c = other_src(prio_last_q);
    if (bus.up_valid_a && !bus.up_valid_b)      grant_src_c = SRC_A;
    else if (bus.up_valid_b && !bus.up_valid_a) grant_src_c = SRC_B;

    ready_a_c  = load_en_c && !rst && (grant_src_c == SRC_A);
    ready_b_c  = load_en_c && !rst && (grant_src_c == SRC_B);
    accept_a_c = ready_a_c && bus.up_valid_a;
    accept_b_c = ready_b_c && bus.up_valid_b;

    in_payload_c = (grant_src_c == SRC_B) ? {1'b1, bus.up_data_b} : {1'b0, bus.up_data_a};

    prio_last_d = prio_last_q;
    if (accept_a_c || accept_b_c) prio_last_d = grant_src_c;

    cnt_a_d = cnt_a_q + CNT_WIDTH'(accept_a_c);
    cnt_b_d = cnt_b_q + CNT_WIDTH'(accept_b_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_last_q <= SRC_B;
      cnt_a_q     <= '0;
      cnt_b_q     <= '0;
    end else begin
      prio_last_q <= prio_last_d;
      cnt_a_q     <= cnt_a_d;
      cnt_b_q     <= cnt_b_d;
    end
  end

  custom_logic_reg_slice #(.P_WIDTH(P_WIDTH)) u_slice (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (accept_a_c || accept_b_c),
    .in_payload  (in_payload_c),
    .load_en_c   (load_en_c),
    .out_ready   (bus.down_ready),
    .out_valid   (out_valid),
    .out_payload (out_payload)
  );

  assign bus.up_ready_a  = ready_a_c;
  assign bus.up_ready_b  = ready_b_c;
  assign bus.down_valid  = out_valid;
  assign bus.down_data   = out_payload[D_WIDTH-1:0];
  assign bus.down_src    = out_payload[D_WIDTH];
  assign bus.grant_cnt_a = cnt_a_q;
  assign bus.grant_cnt_b = cnt_b_q;

endmodule

// File: tb/tb_custom_logic_arbiter.sv
// Scoreboard bench: driver pushes expected beats from a behavioural model, monitor pops and compares.
module tb_custom_logic_arbiter;
  import custom_logic_pkg::*;

  localparam int unsigned DW      = 6;
  localparam int unsigned CW      = 2;
  localparam int          CNT_MOD = 1 << CW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  custom_logic_arbiter_if #(.D_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  custom_logic_arbiter #(.D_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [DW-1:0] data;
    bit            src;
  } beat_t;

  beat_t exp_q[$];
  bit    m_prio;
  int    m_cnt_a;
  int    m_cnt_b;
  int    checks   = 0;
  int    failures = 0;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Round-robin rule: the sole requester wins, on contention the one not served last wins
  function automatic bit grant_b(input bit va, input bit vb);
    if (va && !vb) return 1'b0;
    if (vb && !va) return 1'b1;
    return !m_prio;
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_prio  = 1'b1;
    m_cnt_a = 0;
    m_cnt_b = 0;
  endfunction

  // Evaluate the edge that just happened using the inputs that were presented to it
  function automatic void model_edge();
    bit    gb;
    bit    acc;
    beat_t b;
    if (rst) return;
    gb  = grant_b(bus.up_valid_a, bus.up_valid_b);
    acc = ((exp_q.size() == 0) || bus.down_ready) && (gb ? bus.up_valid_b : bus.up_valid_a);
    if (acc) begin
      b.data = gb ? bus.up_data_b : bus.up_data_a;
      b.src  = gb;
      exp_q.push_back(b);
      m_prio = gb;
      if (gb) m_cnt_b = (m_cnt_b + 1) % CNT_MOD;
      else    m_cnt_a = (m_cnt_a + 1) % CNT_MOD;
    end
  endfunction

  task automatic drive(input bit va, input logic [DW-1:0] da, input bit vb,
                       input logic [DW-1:0] db, input bit dr);
    @(posedge clk);
    #1;
    model_edge();
    bus.up_valid_a = va;
    bus.up_data_a  = da;
    bus.up_valid_b = vb;
    bus.up_data_b  = db;
    bus.down_ready = dr;
  endtask

  // Monitor: handshake rules and scoreboard comparison, sampled mid-cycle
  always @(negedge clk) begin
    bit gb;
    bit ld;
    chk("ready_exclusive", int'(bus.up_ready_a && bus.up_ready_b), 0);
    if (rst) begin
      chk("ready_a_in_reset", int'(bus.up_ready_a), 0);
      chk("ready_b_in_reset", int'(bus.up_ready_b), 0);
    end else if (bus.up_valid_a || bus.up_valid_b) begin
      gb = grant_b(bus.up_valid_a, bus.up_valid_b);
      ld = (exp_q.size() == 0) || bus.down_ready;
      chk("up_ready_a", int'(bus.up_ready_a), int'(ld && !gb));
      chk("up_ready_b", int'(bus.up_ready_b), int'(ld && gb));
    end
    chk("down_valid", int'(bus.down_valid), int'(exp_q.size() != 0));
    if (bus.down_valid && exp_q.size() != 0) begin
      chk("down_data", int'(bus.down_data), int'(exp_q[0].data));
      chk("down_src", int'(bus.down_src), int'(exp_q[0].src));
    end
    if (exp_q.size() != 0 && bus.down_ready) void'(exp_q.pop_front());
    chk("grant_cnt_a", int'(bus.grant_cnt_a), m_cnt_a);
    chk("grant_cnt_b", int'(bus.grant_cnt_b), m_cnt_b);
  end

  initial begin
    rst            = 1'b1;
    bus.up_valid_a = 1'b0;
    bus.up_data_a  = '0;
    bus.up_valid_b = 1'b0;
    bus.up_data_b  = '0;
    bus.down_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_down_data", int'(bus.down_data), 0);
    chk("reset_down_src", int'(bus.down_src), 0);
    #2 rst = 1'b0;

    // Single A beat, then strict alternation under contention
    drive(1'b1, 6'd5, 1'b0, 6'd0, 1'b1);
    drive(1'b0, 6'd0, 1'b0, 6'd0, 1'b1);
    repeat (6) drive(1'b1, 6'd1, 1'b1, 6'd2, 1'b1);

    // Backpressure with both requesters waiting, then release
    repeat (3) drive(1'b1, 6'd1, 1'b1, 6'd2, 1'b0);
    repeat (2) drive(1'b1, 6'd1, 1'b1, 6'd2, 1'b1);

    // Run of B-only beats followed by contention; A must win after B
    repeat (4) drive(1'b0, 6'd0, 1'b1, 6'd3, 1'b1);
    drive(1'b1, 6'd4, 1'b1, 6'd5, 1'b1);
    drive(1'b0, 6'd0, 1'b0, 6'd0, 1'b1);

    // Five A beats exercise counter wrap; withdrawn valid must change nothing
    repeat (5) drive(1'b1, 6'd9, 1'b0, 6'd0, 1'b1);
    drive(1'b0, 6'd0, 1'b0, 6'd0, 1'b1);
    drive(1'b0, 6'd0, 1'b0, 6'd0, 1'b1);

    // Reset while a beat is held under backpressure
    drive(1'b1, 6'd7, 1'b0, 6'd0, 1'b0);
    drive(1'b1, 6'd8, 1'b1, 6'd6, 1'b0);
    @(posedge clk);
    #1;
    model_edge();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_down_valid", int'(bus.down_valid), 0);
    chk("async_reset_cnt_a", int'(bus.grant_cnt_a), 0);
    model_reset();
    repeat (2) @(negedge clk);
    #2;
    bus.up_valid_a = 1'b0;
    bus.up_valid_b = 1'b0;
    bus.down_ready = 1'b1;
    rst            = 1'b0;
    repeat (3) drive(1'b0, 6'd0, 1'b0, 6'd0, 1'b1);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 600; i++) begin
      drive(bit'($urandom_range(0, 1)), DW'($urandom), bit'($urandom_range(0, 1)),
            DW'($urandom), ($urandom_range(0, 3) != 0));
    end

    repeat (4) drive(1'b0, 6'd0, 1'b0, 6'd0, 1'b1);
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/custom_logic_arbiter.md
CUSTOM_LOGIC_ARBITER -- requirements
Module: custom_logic_arbiter

Interface
REQ-001 SHALL have parameter D_WIDTH, default 6, width of each data channel.
REQ-002 SHALL have parameter CNT_WIDTH, default 8, width of per-source grant counters.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports up_data_a / up_valid_a / up_ready_a  in/in/out  D_WIDTH/1/1  requester A stream.
REQ-006 SHALL have ports up_data_b / up_valid_b / up_ready_b  in/in/out  D_WIDTH/1/1  requester B stream.
REQ-007 SHALL have ports down_data / down_valid / down_ready  out/out/in  D_WIDTH/1/1  shared output stream.
REQ-008 SHALL have port down_src  output  1  source of current down_data (0=A, 1=B).
REQ-009 SHALL have ports grant_cnt_a / grant_cnt_b  output  CNT_WIDTH  accepted-beat counters per source.

Function
REQ-010 SHALL transfer a beat on any channel only in a cycle where valid and ready are both 1.
REQ-011 SHALL hold one registered output slot (down_data, down_valid, down_src); outputs SHALL be driven only from registers.
REQ-012 SHALL define load_en = !down_valid | down_ready; a new beat may enter the slot only when load_en=1.
REQ-013 SHALL arbitrate round-robin: only A valid -> grant A; only B valid -> grant B; both valid -> grant the source opposite to prio_last.
REQ-014 SHALL assert up_ready_x = load_en & grant_x; at most one of up_ready_a/up_ready_b SHALL be 1 in any cycle.
REQ-015 SHALL NOT make up_ready depend on its own requester's valid beyond the grant decision (no ready-waits-for-valid loops toward downstream).
REQ-016 SHALL on an accepted beat load down_data = granted up_data, down_src = granted source, down_valid = 1, and set prio_last = granted source.
REQ-017 SHALL leave prio_last unchanged in cycles with no accepted beat.
REQ-018 SHALL clear down_valid when down_ready=1 and no beat is accepted in the same cycle.
REQ-019 SHALL keep down_data/down_src stable while down_valid=1 and down_ready=0.
REQ-020 SHALL sustain one beat per cycle when down_ready is held 1 (downstream pop and upstream accept in the same cycle).
REQ-021 SHALL have latency of exactly 1 cycle from upstream acceptance to down_valid=1.
REQ-022 SHALL increment grant_cnt_x on each accepted beat from source x, wrapping from 2^CNT_WIDTH-1 to 0.
REQ-023 SHALL NOT let a requester drop valid matter: a withdrawn valid with no handshake SHALL leave all state unchanged.

Reset
REQ-024 SHALL, while rst=1, force down_valid=0, down_data=0, down_src=0, grant_cnt_a=0, grant_cnt_b=0, prio_last=1 (so A wins first contention).
REQ-025 SHALL, during rst=1, drive up_ready_a=0 and up_ready_b=0.
REQ-026 SHALL, on reset asserted mid-transfer, discard any held beat; no beat SHALL appear after deassertion without a new handshake.

Structure
REQ-027 SHALL take source encoding (SRC_A=0, SRC_B=1) from shared package custom_logic_pkg.
REQ-028 SHALL implement the output slot as sub-module custom_logic_reg_slice (data+src payload, valid/ready, load_en generation).
REQ-029 SHALL keep arbitration and counters in custom_logic_arbiter itself.

Verification
REQ-030 Reset then A valid data=5, B idle, down_ready=1 -> next cycle down_data=5, down_src=0, grant_cnt_a=1.
REQ-031 A and B both continuously valid (A=1, B=2), down_ready=1 -> outputs alternate 1,2,1,2 starting with A; one beat per cycle.
REQ-032 Slot full, down_ready=0 for 3 cycles, both valid -> up_ready_a=up_ready_b=0, down_data held; on down_ready=1 next beat loads the same cycle.
REQ-033 Only B valid for 4 beats then both valid -> B,B,B,B,A (prio_last=B after B beats).
REQ-034 CNT_WIDTH=2, 5 A beats -> grant_cnt_a sequence 1,2,3,0,1.
REQ-035 Assert rst while down_valid=1 and down_ready=0 -> down_valid=0 immediately; after release no beat until new handshake; counters 0.
